vec_issue_ctrl: RTL and testbench
=================================

// Module: vec_issue_ctrl
// PURPOSE
//  Issue sequencer for the ID/EXE stage. Splits one decoded vector instruction into ceil(vlen/LANES) chunk issues.
//  Drives the stall for IF/ID and PC, and the bubble (NOP) into ID/EXE.
//  Supplies the state and element-base count that the ID/EXE register forwards to EXE.
//  Also inserts single-cycle scalar load-use bubbles.
// PARAMETERS
//  CNT_W      32  width of vlen and element-base counter
//  LANES      4   elements issued per cycle; power of 2, >=1
//  DRAIN_CYC  2   post-vector drain cycles; used only with VEC_DRAIN_EN; >=1
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       reset, asynchronous, active-low
//  id_valid        in   1       valid instruction in ID
//  id_is_vec       in   1       ID instruction is a vector op
//  id_vreg_write   in   1       vector op writes the vector register file
//  id_vlen         in   CNT_W   element count of the ID vector op
//  id_load_use     in   1       scalar load-use hazard detected in ID
//  exe_flush       in   1       taken branch in EXE; squash the ID instruction
//  stall_if        out  1       hold PC and IF/ID
//  bubble_exe      out  1       write NOP controls into ID/EXE
//  next_state      out  2       state code to the ID/EXE next_state input
//  cnt             out  CNT_W   element base of the chunk issued this cycle
//  elem_mask       out  LANES   per-lane enable for this chunk
//  vec_last        out  1       this chunk is the final one
//  busy            out  1       state != IDLE
// BEHAVIOUR
//  Clock and reset: one clock; reset asynchronous, active-low.
//  Registers:
//   - state (IDLE=0, VEC=1, HAZ=2, DRAIN=3), base (CNT_W), drain counter.
//   - While rst_n=0: state=IDLE, base=0, drain=0.
//  Outputs:
//   - All outputs are combinational from registers and inputs; no added latency.
//   - While rst_n=0: stall_if, bubble_exe, vec_last, busy, elem_mask and cnt are all 0.
//   - cnt = base. next_state = state of the following cycle.
//   - Reset mid-operation abandons the instruction; nothing is replayed.
//  Priority in every state: exe_flush > id_load_use (IDLE only) > vector issue.
//  exe_flush=1 (any state):
//   - bubble_exe=1, stall_if=0, elem_mask=0.
//   - Next state IDLE, base=0.
//  IDLE, id_valid=0 or scalar without hazard: all outputs 0; stay IDLE.
//  IDLE, id_load_use=1:
//   - stall_if=1, bubble_exe=1; go to HAZ.
//   - HAZ lasts 1 cycle: stall_if=0, bubble_exe=0; back to IDLE.
//   - Instruction issues normally the following cycle.
//  IDLE, vector:
//   - vlen==0: bubble_exe=1, stall_if=0, elem_mask=0, vec_last=1; stay IDLE.
//   - vlen<=LANES: single issue; elem_mask=(1<<vlen)-1, vec_last=1, stall_if=0.
//   - vlen>LANES: chunk 0 issues with elem_mask all-ones, stall_if=1; base<=LANES; go to VEC.
//  VEC:
//   - rem = vlen - base. Compute rem in CNT_W+1 bits so there is no wrap.
//   - rem>LANES: full mask, stall_if=1, base+=LANES.
//   - Otherwise: mask=(1<<rem)-1, vec_last=1, stall_if=0, base<=0; go to IDLE (or DRAIN, see below).
//  id_vlen and id_vreg_write must stay stable while stalled; IF/ID is held by stall_if.
// CONFIGURATION
//  VEC_DRAIN_EN defined:
//   - After the last chunk with id_vreg_write=1, go to DRAIN for DRAIN_CYC cycles.
//   - In DRAIN: stall_if=1, bubble_exe=1, elem_mask=0. Flush still exits to IDLE.
//  VEC_DRAIN_EN undefined:
//   - DRAIN is unreachable; the last chunk returns to IDLE.
//   - The drain counter is not built.
// STRUCTURE
//  Package vec_ctrl_pkg holds the state codes (IDLE/VEC/HAZ/DRAIN) and the default LANES and CNT_W.
//  One sub-module, vec_tail_mask: rem and LANES in, elem_mask out (saturates to all-ones).
//  The FSM and counters stay in this module.
// TESTING
//  1. LANES=4, vlen=10:
//     cnt 0/4/8; mask 1111/1111/0011; stall 1/1/0; vec_last only on cnt=8; then IDLE.
//  2. vlen=3: one cycle, mask 0111, vec_last=1, stall_if=0; stays IDLE.
//  3. vlen=0: bubble_exe=1, mask 0000, stall_if=0; no state change.
//  4. id_load_use=1 in IDLE:
//     stall=1, bubble=1, then HAZ one cycle, then IDLE; next vec issues with cnt=0.
//  5. vlen=12, exe_flush at cnt=4: bubble=1 that cycle; next cycle IDLE, cnt=0, busy=0.
//  6. rst_n low at cnt=8 of vlen=16: outputs 0 immediately, without a clock edge.
//  7. VEC_DRAIN_EN, DRAIN_CYC=2, vlen=4, vreg_write=1: last chunk, then 2 DRAIN cycles
//     with stall=1, bubble=1; without the macro, IDLE directly.

Source files
------------

// File: rtl/vec_ctrl_pkg.sv
// Shared state codes and default geometry for the vector issue controller.
package vec_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VEC   = 2'd1,
    ST_HAZ   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int DEF_LANES = 4;
  localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/vec_tail_mask.sv
// Per-lane enable for one chunk: lane i is active when more than i elements remain.
// Saturates to all-ones whenever rem >= LANES.
module vec_tail_mask
  import vec_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int LANES = DEF_LANES
) (
  input  logic [CNT_W:0]   rem,
  output logic [LANES-1:0] elem_mask
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign elem_mask[gi] = (rem > (CNT_W+1)'(gi));
    end
  endgenerate

endmodule

// File: rtl/vec_issue_ctrl.sv
// ID/EXE issue sequencer: splits vector ops into LANES-wide chunks and inserts load-use bubbles.
// Optional feature macro VEC_DRAIN_EN adds DRAIN_CYC stall cycles after a vreg-writing vector op.
module vec_issue_ctrl
  import vec_ctrl_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int LANES     = DEF_LANES,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_is_vec,
  input  logic             id_vreg_write,
  input  logic [CNT_W-1:0] id_vlen,
  input  logic             id_load_use,
  input  logic             exe_flush,
  output logic             stall_if,
  output logic             bubble_exe,
  output logic [1:0]       next_state,
  output logic [CNT_W-1:0] cnt,
  output logic [LANES-1:0] elem_mask,
  output logic             vec_last,
  output logic             busy
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] base, base_nx;
  logic [CNT_W:0]   rem;
  logic [LANES-1:0] tail_mask;
  logic             stall_c, bubble_c, last_c, mask_en, chunk;
  logic             drain_go;

  // base is 0 whenever the FSM is IDLE, so rem also serves the first chunk.
  assign rem = {1'b0, id_vlen} - {1'b0, base};

  vec_tail_mask #(
    .CNT_W (CNT_W),
    .LANES (LANES)
  ) u_tail (
    .rem       (rem),
    .elem_mask (tail_mask)
  );

`ifdef VEC_DRAIN_EN
  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);
  logic [DRAIN_W-1:0] drain, drain_nx;
  assign drain_go = id_vreg_write;
`else
  logic unused_cfg;
  assign unused_cfg = id_vreg_write ^ (DRAIN_CYC != 0);
  assign drain_go   = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    base_nx  = base;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    last_c   = 1'b0;
    mask_en  = 1'b0;
    chunk    = 1'b0;
`ifdef VEC_DRAIN_EN
    drain_nx = drain;
`endif
    if (exe_flush) begin
      bubble_c = 1'b1;
      state_nx = ST_IDLE;
      base_nx  = '0;
`ifdef VEC_DRAIN_EN
      drain_nx = '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (id_valid && id_load_use) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            state_nx = ST_HAZ;
          end else if (id_valid && id_is_vec) begin
            if (id_vlen == '0) begin
              bubble_c = 1'b1;
              last_c   = 1'b1;
            end else begin
              chunk = 1'b1;
            end
          end
        end
        ST_VEC:  chunk = 1'b1;
        ST_HAZ:  state_nx = ST_IDLE;
        ST_DRAIN: begin
`ifdef VEC_DRAIN_EN
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (drain == '0) state_nx = ST_IDLE;
          else drain_nx = drain - 1'b1;
`else
          state_nx = ST_IDLE;
`endif
        end
        default: state_nx = ST_IDLE;
      endcase

      if (chunk) begin
        mask_en = 1'b1;
        // A negative rem (vlen changed illegally mid-op) ends the op instead of wrapping.
        if (!rem[CNT_W] && rem > (CNT_W+1)'(LANES)) begin
          stall_c  = 1'b1;
          base_nx  = base + CNT_W'(LANES);
          state_nx = ST_VEC;
        end else begin
          last_c  = 1'b1;
          base_nx = '0;
          if (drain_go) begin
            state_nx = ST_DRAIN;
`ifdef VEC_DRAIN_EN
            drain_nx = DRAIN_W'(DRAIN_CYC - 1);
`endif
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      base  <= '0;
`ifdef VEC_DRAIN_EN
      drain <= '0;
`endif
    end else begin
      state <= state_nx;
      base  <= base_nx;
`ifdef VEC_DRAIN_EN
      drain <= drain_nx;
`endif
    end
  end

  // Outputs are forced quiet the moment rst_n drops, independent of the clock.
  assign stall_if   = rst_n & stall_c;
  assign bubble_exe = rst_n & bubble_c;
  assign vec_last   = rst_n & last_c;
  assign elem_mask  = (rst_n && mask_en) ? tail_mask : '0;
  assign cnt        = rst_n ? base : '0;
  assign busy       = rst_n & (state != ST_IDLE);
  assign next_state = rst_n ? state_nx : ST_IDLE;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Scoreboard bench for vec_issue_ctrl: directed scenarios then randomized traffic against a
// behavioural element-count model. Honors VEC_DRAIN_EN the same way as the design.
module tb_vec_issue_ctrl;

  localparam int CNT_W     = 32;
  localparam int LANES     = 4;
  localparam int DRAIN_CYC = 2;
`ifdef VEC_DRAIN_EN
  localparam bit DRAIN_ON = 1'b1;
`else
  localparam bit DRAIN_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid, id_is_vec, id_vreg_write, id_load_use, exe_flush;
  logic [CNT_W-1:0] id_vlen;
  logic             stall_if, bubble_exe, vec_last, busy;
  logic [1:0]       next_state;
  logic [CNT_W-1:0] cnt;
  logic [LANES-1:0] elem_mask;

  always #5 clk = ~clk;

  vec_issue_ctrl #(
    .CNT_W     (CNT_W),
    .LANES     (LANES),
    .DRAIN_CYC (DRAIN_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_is_vec     (id_is_vec),
    .id_vreg_write (id_vreg_write),
    .id_vlen       (id_vlen),
    .id_load_use   (id_load_use),
    .exe_flush     (exe_flush),
    .stall_if      (stall_if),
    .bubble_exe    (bubble_exe),
    .next_state    (next_state),
    .cnt           (cnt),
    .elem_mask     (elem_mask),
    .vec_last      (vec_last),
    .busy          (busy)
  );

  typedef struct packed {
    logic             stall;
    logic             bubble;
    logic [1:0]       ns;
    logic [CNT_W-1:0] cnt;
    logic [LANES-1:0] mask;
    logic             last;
    logic             busy;
  } resp_t;

  resp_t exp_q[$];
  string tag_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    n_txn  = 0;

  // Model: how many elements of the current vector op are already issued, plus pending bubbles.
  bit          m_vec = 0, m_haz = 0, prev_stall = 0;
  int unsigned m_done = 0, m_drain = 0;
  // Instruction currently sitting in ID (held while the pipeline is stalled).
  bit          h_valid = 0, h_vec = 0, h_vrw = 0, h_lu = 0;
  int unsigned h_vlen = 0;

  task automatic step(input bit valid, input bit is_vec, input bit vrw, input int unsigned vlen,
                      input bit lu, input bit flush, input bit rst, input string tag);
    resp_t       e;
    bit          do_issue;
    int unsigned rem;
    @(posedge clk);
    #1;
    if (!rst && !rst_n) rst_n = 1'b1;
    if (!prev_stall) begin
      h_valid = valid; h_vec = is_vec; h_vrw = vrw; h_vlen = vlen; h_lu = lu;
    end
    id_valid = h_valid; id_is_vec = h_vec; id_vreg_write = h_vrw;
    id_vlen = CNT_W'(h_vlen); id_load_use = h_lu; exe_flush = flush;
    e = '0;
    do_issue = 0;
    rem = 0;
    if (rst) begin
      #1 rst_n = 1'b0;
      m_vec = 0; m_haz = 0; m_done = 0; m_drain = 0; prev_stall = 0;
    end else begin
      e.busy = m_vec || m_haz || (m_drain > 0);
      e.cnt  = m_vec ? CNT_W'(m_done) : '0;
      if (flush) begin
        e.bubble = 1; m_vec = 0; m_haz = 0; m_drain = 0; m_done = 0;
      end else if (m_drain > 0) begin
        e.stall = 1; e.bubble = 1; m_drain--;
      end else if (m_haz) begin
        m_haz = 0;
      end else if (m_vec) begin
        do_issue = 1; rem = h_vlen - m_done;
      end else if (h_valid && h_lu) begin
        e.stall = 1; e.bubble = 1; m_haz = 1;
      end else if (h_valid && h_vec) begin
        if (h_vlen == 0) begin
          e.bubble = 1; e.last = 1;
        end else begin
          do_issue = 1; rem = h_vlen;
        end
      end
      if (do_issue) begin
        e.mask = (rem >= LANES) ? {LANES{1'b1}} : LANES'((1 << rem) - 1);
        if (rem > LANES) begin
          e.stall = 1; m_done += LANES; m_vec = 1;
        end else begin
          e.last = 1; m_vec = 0; m_done = 0;
          if (DRAIN_ON && h_vrw) m_drain = DRAIN_CYC;
        end
      end
      e.ns = (m_drain > 0) ? 2'd3 : m_haz ? 2'd2 : m_vec ? 2'd1 : 2'd0;
      prev_stall = e.stall;
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  initial begin : monitor
    resp_t e, a;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {stall_if, bubble_exe, next_state, cnt, elem_mask, vec_last, busy};
        n_cmp++;
        n_txn++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL txn %0d %s: got stall=%0b bubble=%0b ns=%0d cnt=%0d mask=%b last=%0b busy=%0b, want stall=%0b bubble=%0b ns=%0d cnt=%0d mask=%b last=%0b busy=%0b",
                   n_txn, t, a.stall, a.bubble, a.ns, a.cnt, a.mask, a.last, a.busy,
                   e.stall, e.bubble, e.ns, e.cnt, e.mask, e.last, e.busy);
        end else begin
          $display("txn %0d %s: stall=%0b bubble=%0b ns=%0d cnt=%0d mask=%b last=%0b busy=%0b",
                   n_txn, t, a.stall, a.bubble, a.ns, a.cnt, a.mask, a.last, a.busy);
        end
      end
    end
  end

  initial begin : stimulus
    bit          r_valid, r_vec, r_vrw, r_lu, r_flush, r_rst;
    int unsigned r_vlen;
    id_valid = 0; id_is_vec = 0; id_vreg_write = 0; id_vlen = '0; id_load_use = 0; exe_flush = 0;

    step(1, 1, 0, 0, 0, 0, 1, "reset_a");
    step(1, 1, 1, 10, 1, 0, 1, "reset_b");
    repeat (3) step(1, 1, 0, 10, 0, 0, 0, "vlen10");
    step(1, 1, 0, 3, 0, 0, 0, "vlen3");
    step(1, 1, 0, 0, 0, 0, 0, "vlen0");
    step(0, 0, 0, 0, 0, 0, 0, "idle");
    step(1, 1, 0, 4, 0, 0, 0, "vlen4");
    step(1, 1, 0, 5, 0, 0, 0, "vlen5");
    step(1, 1, 0, 5, 0, 0, 0, "vlen5");
    step(1, 0, 0, 0, 1, 0, 0, "loaduse");
    step(1, 0, 0, 0, 1, 0, 0, "haz");
    repeat (2) step(1, 1, 0, 6, 0, 0, 0, "vec_after_haz");
    step(1, 1, 0, 12, 0, 0, 0, "vlen12");
    step(1, 1, 0, 12, 0, 1, 0, "vlen12_flush");
    step(0, 0, 0, 0, 0, 0, 0, "after_flush");
    repeat (3) step(1, 1, 0, 16, 0, 0, 0, "vlen16");
    step(1, 1, 0, 16, 0, 0, 1, "vlen16_rst");
    step(0, 0, 0, 0, 0, 0, 0, "after_rst");
    step(1, 1, 1, 4, 0, 0, 0, "vlen4_vrw");
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, "post_vrw");
    repeat (2) step(1, 1, 1, 7, 0, 0, 0, "vlen7_vrw");
    step(1, 1, 1, 7, 0, 1, 0, "drain_flush");

    repeat (500) begin
      r_valid = ($urandom_range(0, 3) != 0);
      r_vec   = ($urandom_range(0, 2) != 0);
      r_vrw   = $urandom_range(0, 1) == 1;
      r_vlen  = $urandom_range(0, 17);
      r_lu    = ($urandom_range(0, 5) == 0);
      r_flush = ($urandom_range(0, 11) == 0);
      r_rst   = ($urandom_range(0, 59) == 0);
      step(r_valid, r_vec, r_vrw, r_vlen, r_lu, r_flush, r_rst, "rand");
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: %0d responses never observed, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
